// File: rtl/fprint_arbiter.sv
// Round-robin arbiter sharing one comparator fingerprint write port among NUM_CORES cores.
// The low/high fingerprint halves are kept atomic, and a watchdog breaks a lock abandoned after the low half.
module fprint_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int CRC_OFFSET   = 4,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES*4-1:0]          core_address,
  input  logic [NUM_CORES-1:0]            core_write,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_writedata,
  output logic [NUM_CORES-1:0]            core_waitrequest,
  output logic [ADDR_WIDTH-1:0]           fprint_address,
  output logic                            fprint_write,
  output logic [DATA_WIDTH-1:0]           fprint_writedata,
  input  logic                            fprint_waitrequest,
  output logic                            grant_valid,
  output logic [3:0]                      grant_id,
  output logic                            lock_timeout,
  output logic [NUM_CORES-1:0]            timeout_status,
  input  logic [NUM_CORES-1:0]            clear_timeout
);
  localparam int PW = $clog2(NUM_CORES);
  localparam int CW = $clog2(LOCK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_HOLD} state_t;

  state_t                state_q;
  logic [PW-1:0]         gid_q, rr_q;
  logic [CW-1:0]         cnt_q;
  logic                  lock_to_q;
  logic [NUM_CORES-1:0]  tstat_q, tstat_d;

  logic [3:0]            off_a [NUM_CORES];
  logic [DATA_WIDTH-1:0] dat_a [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign off_a[i] = core_address[4*i +: 4];
    assign dat_a[i] = core_writedata[DATA_WIDTH*i +: DATA_WIDTH];
  end

  logic                  own_wr, xfer, done, low_half, timeout_hit, pick_hit;
  logic [3:0]            own_off;
  logic [DATA_WIDTH-1:0] own_dat;
  logic [PW-1:0]         rr_next, pick_id;
  logic [NUM_CORES-1:0]  req_rot;

  assign own_wr   = core_write[gid_q];
  assign own_off  = off_a[gid_q];
  assign own_dat  = dat_a[gid_q];
  assign xfer     = (state_q == S_XFER);
  assign done     = xfer && own_wr && !fprint_waitrequest;
  assign low_half = (own_off == 4'(CRC_OFFSET)) && !own_dat[5];
  assign rr_next  = (gid_q == PW'(NUM_CORES-1)) ? '0 : gid_q + 1'b1;

  assign timeout_hit = (state_q == S_HOLD) && !own_wr && (cnt_q == CW'(LOCK_TIMEOUT-1));
  // Set takes priority over a same-cycle clear.
  assign tstat_d = (tstat_q & ~clear_timeout) |
                   (timeout_hit ? (NUM_CORES'(1) << gid_q) : '0);

  // Rotate requests so bit 0 is the core at rr_q; the lowest set bit wins.
  assign req_rot = NUM_CORES'({core_write, core_write} >> rr_q);

  always_comb begin
    pick_hit = 1'b0;
    pick_id  = '0;
    for (int j = NUM_CORES-1; j >= 0; j--) begin
      if (req_rot[j]) begin
        pick_hit = 1'b1;
        pick_id  = PW'((int'(rr_q) + j >= NUM_CORES) ? int'(rr_q) + j - NUM_CORES
                                                     : int'(rr_q) + j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gid_q     <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      lock_to_q <= 1'b0;
      tstat_q   <= '0;
    end else begin
      lock_to_q <= timeout_hit;
      tstat_q   <= tstat_d;
      case (state_q)
        S_IDLE: if (pick_hit) begin
          gid_q   <= pick_id;
          state_q <= S_XFER;
        end
        S_XFER: if (done) begin
          if (low_half) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
            rr_q    <= rr_next;
          end
        end
        S_HOLD: begin
          if (own_wr) begin
            state_q <= S_XFER;
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
            rr_q    <= rr_next;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    core_waitrequest = '1;
    if (xfer) core_waitrequest[gid_q] = fprint_waitrequest;
  end

  assign fprint_write     = xfer && own_wr;
  assign fprint_address   = xfer ? ADDR_WIDTH'({gid_q, own_off}) : '0;
  assign fprint_writedata = xfer ? own_dat : '0;
  assign grant_valid      = (state_q != S_IDLE);
  assign grant_id         = 4'(gid_q);
  assign lock_timeout     = lock_to_q;
  assign timeout_status   = tstat_q;
endmodule

// File: tb/tb_fprint_arbiter.sv
// Bench for fprint_arbiter: an owner/lock model checked every cycle, plus directed scenarios
// with literal expectations on comparator traffic, grant order, and timeout behaviour.
module tb_fprint_arbiter;
  localparam int NC = 4;
  localparam int LT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic tw [NC];
  logic [3:0]  ta [NC];
  logic [31:0] td [NC];
  logic fw;
  logic [NC-1:0] clr;

  logic [NC*4-1:0]  core_address;
  logic [NC-1:0]    core_write;
  logic [NC*32-1:0] core_writedata;
  logic [NC-1:0]    core_waitrequest;
  logic [7:0]       fprint_address;
  logic             fprint_write;
  logic [31:0]      fprint_writedata;
  logic             grant_valid;
  logic [3:0]       grant_id;
  logic             lock_timeout;
  logic [NC-1:0]    timeout_status;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      core_write[i]             = tw[i];
      core_address[4*i +: 4]    = ta[i];
      core_writedata[32*i +: 32] = td[i];
    end
  end

  fprint_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(8), .DATA_WIDTH(32),
                   .CRC_OFFSET(4), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(rst_n),
    .core_address(core_address), .core_write(core_write),
    .core_writedata(core_writedata), .core_waitrequest(core_waitrequest),
    .fprint_address(fprint_address), .fprint_write(fprint_write),
    .fprint_writedata(fprint_writedata), .fprint_waitrequest(fw),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .lock_timeout(lock_timeout), .timeout_status(timeout_status),
    .clear_timeout(clr));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: who owns the port, whether it still owes a high half, stall count, fairness pointer.
  int   m_owner = -1, m_last = 0, m_ptr = 0, m_stall = 0;
  bit   m_high = 0, m_pulse = 0, started = 0;
  logic [NC-1:0] m_sticky = '0;

  always @(posedge clk) begin : model
    automatic int o = m_owner, l = m_last, p = m_ptr, s = m_stall;
    automatic bit h = m_high, pu = 1'b0;
    automatic logic [NC-1:0] sk = m_sticky;
    if (!rst_n) begin
      o = -1; l = 0; p = 0; s = 0; h = 0; sk = '0;
    end else begin
      sk = sk & ~clr;
      if (o < 0) begin
        for (int k = NC-1; k >= 0; k--)
          if (tw[(p + k) % NC]) o = (p + k) % NC;
        if (o >= 0) begin l = o; h = 0; end
      end else if (!h) begin
        if (tw[o] && !fw) begin
          if (ta[o] == 4'd4 && !td[o][5]) begin h = 1; s = 0; end
          else begin p = (o + 1) % NC; o = -1; end
        end
      end else if (tw[o]) begin
        h = 0;
      end else if (s == LT-1) begin
        pu = 1; sk[o] = 1'b1; p = (o + 1) % NC; o = -1; h = 0;
      end else begin
        s = s + 1;
      end
    end
    m_owner  <= o; m_last <= l; m_ptr <= p; m_stall <= s;
    m_high   <= h; m_pulse <= pu; m_sticky <= sk;
    started  <= 1'b1;
  end

  logic [7:0]  addr_log [$];
  logic [31:0] dat_log  [$];
  logic [3:0]  gid_log  [$];

  always @(negedge clk) begin : compare
    automatic logic         e_wr = 1'b0;
    automatic logic [7:0]   e_addr = '0;
    automatic logic [31:0]  e_dat = '0;
    automatic logic [NC-1:0] e_wait = '1;
    if (started) begin
      if (m_owner >= 0 && !m_high) begin
        e_wr   = tw[m_owner];
        e_addr = 8'(m_owner * 16 + int'(ta[m_owner]));
        e_dat  = td[m_owner];
        e_wait[m_owner] = fw;
      end
      chk("fprint_write", fprint_write, e_wr);
      chk("fprint_address", fprint_address, e_addr);
      chk("fprint_writedata", fprint_writedata, e_dat);
      chk("core_waitrequest", core_waitrequest, e_wait);
      chk("grant_valid", grant_valid, m_owner >= 0);
      chk("grant_id", grant_id, 4'(m_last));
      chk("lock_timeout", lock_timeout, m_pulse);
      chk("timeout_status", timeout_status, m_sticky);
      if (fprint_write && !fw) begin
        addr_log.push_back(fprint_address);
        dat_log.push_back(fprint_writedata);
        gid_log.push_back(grant_id);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NC; i++) begin tw[i] = 0; ta[i] = '0; td[i] = '0; end
    fw = 0; clr = '0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle_inputs();
    repeat (2) tick();
    rst_n = 1;
    addr_log.delete(); dat_log.delete(); gid_log.delete();
  endtask

  task automatic core_wr(input int id, input logic [3:0] off, input logic [31:0] d);
    automatic bit acc = 0;
    ta[id] = off; td[id] = d; tw[id] = 1;
    for (int n = 0; n < 60 && !acc; n++) begin
      @(negedge clk); acc = !core_waitrequest[id];
      @(posedge clk); #1;
    end
    tw[id] = 0;
    chk("core_wr_accept", acc, 1'b1);
  endtask

  initial begin
    rst_n = 0; idle_inputs();
    repeat (2) tick();
    at_neg();
    chk("rst_wait", core_waitrequest, 4'hF);
    chk("rst_fwrite", fprint_write, 0);
    chk("rst_addr", fprint_address, 0);
    chk("rst_gvalid", grant_valid, 0);
    chk("rst_status", timeout_status, 0);
    tick();

    // Single core write, then rr pointer points past core 1.
    do_reset();
    tw[1] = 1; ta[1] = 4'd0; td[1] = 32'h10;
    tick(); at_neg();
    chk("single_addr", fprint_address, 8'h10);
    chk("single_data", fprint_writedata, 32'h10);
    chk("single_wait", core_waitrequest, 4'b1101);
    tick(); tw[1] = 0;
    tick();
    tw[0] = 1; tw[3] = 1; td[3] = 32'h3;
    tick(); at_neg();
    chk("rr_after_single", grant_id, 4'd3);
    tick(); tw[3] = 0;
    tick(); tick(); tw[0] = 0; tick();

    // Two simultaneous fingerprint pairs stay atomic.
    do_reset();
    fork
      begin core_wr(0, 4'd4, 32'h100); core_wr(0, 4'd4, 32'h120); end
      begin core_wr(1, 4'd4, 32'h200); core_wr(1, 4'd4, 32'h220); end
    join
    tick();
    chk("pair_cnt", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("pair_a0", addr_log[0], 8'h04); chk("pair_a1", addr_log[1], 8'h04);
      chk("pair_a2", addr_log[2], 8'h14); chk("pair_a3", addr_log[3], 8'h14);
      chk("pair_d1", dat_log[1], 32'h120); chk("pair_d2", dat_log[2], 32'h200);
    end

    // Fairness with all cores writing continuously.
    do_reset();
    for (int i = 0; i < NC; i++) begin tw[i] = 1; ta[i] = 4'd0; td[i] = 32'(i); end
    for (int n = 0; n < 100 && gid_log.size() < 6; n++) tick();
    idle_inputs();
    tick();
    chk("fair_cnt", gid_log.size(), 6);
    begin
      automatic int exp_g [6] = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6 && i < gid_log.size(); i++) chk("fair_order", gid_log[i], 4'(exp_g[i]));
    end

    // Comparator wait states during the high half.
    do_reset();
    tw[2] = 1; ta[2] = 4'd4; td[2] = 32'h11;
    tick(); tick();
    td[2] = 32'h31; fw = 1;
    tick(); at_neg();
    chk("ws_wait", core_waitrequest, 4'hF);
    chk("ws_fwrite", fprint_write, 1);
    repeat (5) tick();
    fw = 0;
    tick(); tw[2] = 0;
    tick();
    chk("ws_cnt", dat_log.size(), 2);
    if (dat_log.size() == 2) chk("ws_high", dat_log[1], 32'h31);

    // Abandoned low half: lock broken after LT HOLD cycles, core 3 next.
    do_reset();
    tw[2] = 1; ta[2] = 4'd4; td[2] = 32'h0;
    tw[3] = 1; ta[3] = 4'd0; td[3] = 32'h33;
    tick(); tick(); tw[2] = 0;
    repeat (LT) tick();
    at_neg();
    chk("to_pulse", lock_timeout, 1);
    chk("to_status", timeout_status, 4'b0100);
    tick(); at_neg();
    chk("to_next_gid", grant_id, 4'd3);
    chk("to_next_addr", fprint_address, 8'h30);
    tick(); tw[3] = 0; clr = 4'b0100;
    tick(); clr = '0;
    at_neg();
    chk("to_cleared", timeout_status, 4'b0000);
    tick();

    // Owner returns in the final HOLD cycle: no timeout.
    do_reset();
    tw[2] = 1; ta[2] = 4'd4; td[2] = 32'h0;
    tick(); tick(); tw[2] = 0;
    repeat (LT-1) tick();
    tw[2] = 1; td[2] = 32'h20;
    tick(); at_neg();
    chk("late_pulse", lock_timeout, 0);
    chk("late_fwrite", fprint_write, 1);
    tick(); tw[2] = 0;
    tick();

    // Reset while holding aborts the lock; next grant from core 0.
    do_reset();
    tw[1] = 1; ta[1] = 4'd4; td[1] = 32'h0;
    tick(); tick(); tw[1] = 0;
    rst_n = 0;
    tick(); at_neg();
    chk("rh_wait", core_waitrequest, 4'hF);
    chk("rh_fwrite", fprint_write, 0);
    chk("rh_gvalid", grant_valid, 0);
    tick();
    rst_n = 1;
    tw[0] = 1; td[0] = 32'h5; tw[2] = 1; td[2] = 32'h6;
    tick(); at_neg();
    chk("rh_gid", grant_id, 4'd0);
    tick(); tw[0] = 0;
    tick(); tick(); tw[2] = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
